// File: rtl/fc8_cpu_pkg.sv
// FC8 shared definitions: opcode encodings, flag bit positions, FSM states.
// Pure declarations; no timing or bus behaviour of its own.
package fc8_cpu_pkg;

   localparam logic [7:0] OP_LDA_IMM = 8'hA9;
   localparam logic [7:0] OP_LDA_ABS = 8'hAD;
   localparam logic [7:0] OP_STA_ABS = 8'h8D;
   localparam logic [7:0] OP_LDX_IMM = 8'hA2;
   localparam logic [7:0] OP_LDY_IMM = 8'hA0;
   localparam logic [7:0] OP_ADC_IMM = 8'h69;
   localparam logic [7:0] OP_CLC     = 8'h18;
   localparam logic [7:0] OP_SEC     = 8'h38;
   localparam logic [7:0] OP_CLI     = 8'h58;
   localparam logic [7:0] OP_SEI     = 8'h78;
   localparam logic [7:0] OP_NOP     = 8'hEA;
   localparam logic [7:0] OP_BCS_REL = 8'hB0;
   localparam logic [7:0] OP_BCC_REL = 8'h90;
   localparam logic [7:0] OP_BEQ_REL = 8'hF0;
   localparam logic [7:0] OP_BNE_REL = 8'hD0;
   localparam logic [7:0] OP_JMP_ABS = 8'h4C;
   localparam logic [7:0] OP_PHA     = 8'h48;
   localparam logic [7:0] OP_PLA     = 8'h68;
   localparam logic [7:0] OP_PHP     = 8'h08;
   localparam logic [7:0] OP_PLP     = 8'h28;

   localparam int C_FLAG_BIT = 0;
   localparam int Z_FLAG_BIT = 1;
   localparam int I_FLAG_BIT = 2;
   localparam int D_FLAG_BIT = 3;
   localparam int B_FLAG_BIT = 4;
   localparam int V_FLAG_BIT = 6;
   localparam int N_FLAG_BIT = 7;

   localparam logic [7:0] F_RESET = 8'h24;

   typedef enum logic [3:0] {
      ST_VEC_LO,
      ST_VEC_HI,
      ST_FETCH,
      ST_DECODE,
      ST_IMM,
      ST_ABS_LO,
      ST_ABS_HI,
      ST_ABS_RD,
      ST_ABS_WR,
      ST_PUSH,
      ST_PULL
   } state_t;

   function automatic logic [7:0] set_nz(input logic [7:0] flags, input logic [7:0] val);
      logic [7:0] r;
      r = flags;
      r[N_FLAG_BIT] = val[7];
      r[Z_FLAG_BIT] = (val == 8'h00);
      return r;
   endfunction

endpackage

// File: rtl/fc8_alu.sv
// FC8 binary add-with-carry and flag generation; purely combinational.
// No state, no handshake: outputs follow inputs in the same cycle.
module fc8_alu (
   input  logic [7:0] a,
   input  logic [7:0] m,
   input  logic       c_in,
   output logic [7:0] sum,
   output logic       c_out,
   output logic       v_out,
   output logic       n_out,
   output logic       z_out
);

   logic [8:0] full;

   assign full  = {1'b0, a} + {1'b0, m} + {8'h00, c_in};
   assign sum   = full[7:0];
   assign c_out = full[8];
   // Overflow: operands share a sign that the result does not.
   assign v_out = ~(a[7] ^ m[7]) & (a[7] ^ sum[7]);
   assign n_out = sum[7];
   assign z_out = (sum == 8'h00);

endmodule

// File: rtl/fc8_cpu.sv
// FC8 multi-cycle 8-bit CPU; one FSM state per clk, zero-wait-state memory port.
// Sole bus master: bus outputs are registered and set on entry to each bus state.
module fc8_cpu
   import fc8_cpu_pkg::*;
#(
   parameter logic [15:0] RESET_VEC = 16'hFFFC,
   parameter logic [15:0] SP_INIT   = 16'h0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  mem_data_in,
   output logic [15:0] mem_addr_out,
   output logic [7:0]  mem_data_out,
   output logic        mem_rd_en,
   output logic        mem_wr_en,
   input  logic        irq_n,
   input  logic        nmi_n
);

   state_t      state;
   logic [15:0] pc;
   logic [7:0]  opcode;
   logic [7:0]  a;
   logic [7:0]  x;
   logic [7:0]  y;
   logic [15:0] sp;
   logic [7:0]  f;
   logic [7:0]  ea_lo;

   logic [7:0]  alu_sum;
   logic        alu_c;
   logic        alu_v;
   logic        alu_n;
   logic        alu_z;
   logic [15:0] pc_inc;
   logic [15:0] br_target;
   logic [15:0] imm_pc;
   logic [15:0] abs_ea;
   logic        br_taken;
   logic        unused_irq;

   assign unused_irq = &{1'b0, irq_n, nmi_n};

   fc8_alu u_alu (
      .a     (a),
      .m     (mem_data_in),
      .c_in  (f[C_FLAG_BIT]),
      .sum   (alu_sum),
      .c_out (alu_c),
      .v_out (alu_v),
      .n_out (alu_n),
      .z_out (alu_z)
   );

   assign pc_inc    = pc + 16'd1;
   assign br_target = pc_inc + {{8{mem_data_in[7]}}, mem_data_in};
   assign abs_ea    = {mem_data_in, ea_lo};

   always_comb begin
      br_taken = 1'b0;
      case (opcode)
         OP_BCS_REL: br_taken = f[C_FLAG_BIT];
         OP_BCC_REL: br_taken = ~f[C_FLAG_BIT];
         OP_BEQ_REL: br_taken = f[Z_FLAG_BIT];
         OP_BNE_REL: br_taken = ~f[Z_FLAG_BIT];
         default:    br_taken = 1'b0;
      endcase
   end

   assign imm_pc = br_taken ? br_target : pc_inc;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state        <= ST_VEC_LO;
         pc           <= 16'h0000;
         opcode       <= OP_NOP;
         a            <= 8'h00;
         x            <= 8'h00;
         y            <= 8'h00;
         sp           <= SP_INIT;
         f            <= F_RESET;
         ea_lo        <= 8'h00;
         mem_addr_out <= 16'h0000;
         mem_data_out <= 8'h00;
         mem_rd_en    <= 1'b0;
         mem_wr_en    <= 1'b0;
      end else begin
         mem_rd_en <= 1'b0;
         mem_wr_en <= 1'b0;
         case (state)
            // First cycle after reset only arms the vector read.
            ST_VEC_LO: begin
               if (!mem_rd_en) begin
                  mem_addr_out <= RESET_VEC;
                  mem_rd_en    <= 1'b1;
               end else begin
                  pc[7:0]      <= mem_data_in;
                  mem_addr_out <= RESET_VEC + 16'd1;
                  mem_rd_en    <= 1'b1;
                  state        <= ST_VEC_HI;
               end
            end
            ST_VEC_HI: begin
               pc[15:8]     <= mem_data_in;
               mem_addr_out <= {mem_data_in, pc[7:0]};
               mem_rd_en    <= 1'b1;
               state        <= ST_FETCH;
            end
            ST_FETCH: begin
               opcode <= mem_data_in;
               pc     <= pc_inc;
               state  <= ST_DECODE;
            end
            ST_DECODE: begin
               case (opcode)
                  OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_ADC_IMM,
                  OP_BCS_REL, OP_BCC_REL, OP_BEQ_REL, OP_BNE_REL: begin
                     mem_addr_out <= pc;
                     mem_rd_en    <= 1'b1;
                     state        <= ST_IMM;
                  end
                  OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS: begin
                     mem_addr_out <= pc;
                     mem_rd_en    <= 1'b1;
                     state        <= ST_ABS_LO;
                  end
                  OP_PHA, OP_PHP: begin
                     mem_addr_out <= sp;
                     mem_data_out <= (opcode == OP_PHA) ? a : (f | 8'h30);
                     mem_wr_en    <= 1'b1;
                     state        <= ST_PUSH;
                  end
                  OP_PLA, OP_PLP: begin
                     sp           <= sp - 16'd1;
                     mem_addr_out <= sp - 16'd1;
                     mem_rd_en    <= 1'b1;
                     state        <= ST_PULL;
                  end
                  default: begin
                     case (opcode)
                        OP_CLC:  f[C_FLAG_BIT] <= 1'b0;
                        OP_SEC:  f[C_FLAG_BIT] <= 1'b1;
                        OP_CLI:  f[I_FLAG_BIT] <= 1'b0;
                        OP_SEI:  f[I_FLAG_BIT] <= 1'b1;
                        default: ;
                     endcase
                     mem_addr_out <= pc;
                     mem_rd_en    <= 1'b1;
                     state        <= ST_FETCH;
                  end
               endcase
            end
            ST_IMM: begin
               case (opcode)
                  OP_LDA_IMM: begin
                     a <= mem_data_in;
                     f <= set_nz(f, mem_data_in);
                  end
                  OP_LDX_IMM: begin
                     x <= mem_data_in;
                     f <= set_nz(f, mem_data_in);
                  end
                  OP_LDY_IMM: begin
                     y <= mem_data_in;
                     f <= set_nz(f, mem_data_in);
                  end
                  OP_ADC_IMM: begin
                     a <= alu_sum;
                     f <= {alu_n, alu_v, f[5:2], alu_z, alu_c};
                  end
                  default: ;
               endcase
               pc           <= imm_pc;
               mem_addr_out <= imm_pc;
               mem_rd_en    <= 1'b1;
               state        <= ST_FETCH;
            end
            ST_ABS_LO: begin
               ea_lo        <= mem_data_in;
               pc           <= pc_inc;
               mem_addr_out <= pc_inc;
               mem_rd_en    <= 1'b1;
               state        <= ST_ABS_HI;
            end
            ST_ABS_HI: begin
               mem_addr_out <= abs_ea;
               if (opcode == OP_JMP_ABS) begin
                  pc        <= abs_ea;
                  mem_rd_en <= 1'b1;
                  state     <= ST_FETCH;
               end else if (opcode == OP_STA_ABS) begin
                  pc           <= pc_inc;
                  mem_data_out <= a;
                  mem_wr_en    <= 1'b1;
                  state        <= ST_ABS_WR;
               end else begin
                  pc        <= pc_inc;
                  mem_rd_en <= 1'b1;
                  state     <= ST_ABS_RD;
               end
            end
            ST_ABS_RD: begin
               a            <= mem_data_in;
               f            <= set_nz(f, mem_data_in);
               mem_addr_out <= pc;
               mem_rd_en    <= 1'b1;
               state        <= ST_FETCH;
            end
            ST_ABS_WR: begin
               mem_addr_out <= pc;
               mem_rd_en    <= 1'b1;
               state        <= ST_FETCH;
            end
            ST_PUSH: begin
               sp           <= sp + 16'd1;
               mem_addr_out <= pc;
               mem_rd_en    <= 1'b1;
               state        <= ST_FETCH;
            end
            ST_PULL: begin
               if (opcode == OP_PLA) begin
                  a <= mem_data_in;
                  f <= set_nz(f, mem_data_in);
               end else begin
                  f <= mem_data_in | 8'h20;
               end
               mem_addr_out <= pc;
               mem_rd_en    <= 1'b1;
               state        <= ST_FETCH;
            end
            default: begin
               mem_addr_out <= pc;
               mem_rd_en    <= 1'b1;
               state        <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc8_cpu.sv
// Directed-program bench for fc8_cpu against a 64 KiB combinational-read memory.
module tb_fc8_cpu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  mem_data_in;
   logic [15:0] mem_addr_out;
   logic [7:0]  mem_data_out;
   logic        mem_rd_en;
   logic        mem_wr_en;
   logic        irq_n = 1'b1;
   logic        nmi_n = 1'b1;

   logic [7:0]  mem [0:65535];
   logic [7:0]  prog [$];
   int          n_checks = 0;
   int          n_pass = 0;
   logic        both_seen = 1'b0;
   logic [15:0] first;

   fc8_cpu dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_data_in  (mem_data_in),
      .mem_addr_out (mem_addr_out),
      .mem_data_out (mem_data_out),
      .mem_rd_en    (mem_rd_en),
      .mem_wr_en    (mem_wr_en),
      .irq_n        (irq_n),
      .nmi_n        (nmi_n)
   );

   always #5 clk = ~clk;

   assign mem_data_in = mem[mem_addr_out];

   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_addr_out] = mem_data_out;
   end

   always @(negedge clk) begin
      if (mem_rd_en && mem_wr_en) both_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic setup(input logic [15:0] vec, input logic [15:0] org);
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'hFFFC] = vec[7:0];
      mem[16'hFFFD] = vec[15:8];
      for (int i = 0; i < prog.size(); i++) mem[org + 16'(i)] = prog[i];
   endtask

   task automatic do_reset();
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
   endtask

   task automatic run(input int cycles, output logic [15:0] first_fetch);
      logic got;
      got = 1'b0;
      first_fetch = 16'hDEAD;
      repeat (cycles) begin
         @(negedge clk);
         if (!got && mem_rd_en && mem_addr_out != 16'hFFFC && mem_addr_out != 16'hFFFD) begin
            first_fetch = mem_addr_out;
            got = 1'b1;
         end
      end
   endtask

   task automatic check_loop(input string tag, input logic [15:0] lo, input logic [15:0] hi);
      logic ok;
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (dut.pc < lo || dut.pc > hi) ok = 1'b0;
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   initial begin
      logic seen;
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      #1;
      check("rst_pc",     dut.pc,       16'h0000);
      check("rst_a",      dut.a,        8'h00);
      check("rst_x",      dut.x,        8'h00);
      check("rst_y",      dut.y,        8'h00);
      check("rst_sp",     dut.sp,       16'h0100);
      check("rst_f",      dut.f,        8'h24);
      check("rst_opcode", dut.opcode,   8'hEA);
      check("rst_rd",     mem_rd_en,    1'b0);
      check("rst_wr",     mem_wr_en,    1'b0);
      check("rst_addr",   mem_addr_out, 16'h0000);
      check("rst_dout",   mem_data_out, 8'h00);

      // LDA #C3; STA $0020; JMP $0205
      prog = '{8'hA9, 8'hC3, 8'h8D, 8'h20, 8'h00, 8'h4C, 8'h05, 8'h02};
      setup(16'h0200, 16'h0200);
      do_reset();
      run(100, first);
      check("first_fetch", first, 16'h0200);
      check("sta_mem",     mem[16'h0020], 8'hC3);
      check("sta_a",       dut.a, 8'hC3);
      check("sta_f",       dut.f, 8'hA4);
      check_loop("sta_loop", 16'h0205, 16'h0208);

      // LDA #n; ADC #01; JMP $0204
      prog = '{8'hA9, 8'hC3, 8'h69, 8'h01, 8'h4C, 8'h04, 8'h02};
      setup(16'h0200, 16'h0200);
      do_reset();
      run(60, first);
      check("adc_c3_a", dut.a, 8'hC4);
      check("adc_c3_f", dut.f, 8'hA4);
      prog[1] = 8'h7F;
      setup(16'h0200, 16'h0200);
      do_reset();
      run(60, first);
      check("adc_7f_a", dut.a, 8'h80);
      check("adc_7f_f", dut.f, 8'hE4);
      prog[1] = 8'hFF;
      setup(16'h0200, 16'h0200);
      do_reset();
      run(60, first);
      check("adc_ff_a", dut.a, 8'h00);
      check("adc_ff_f", dut.f, 8'h27);

      // CLC; BCS +2; LDA $0020; JMP $0206
      prog = '{8'h18, 8'hB0, 8'h02, 8'hAD, 8'h20, 8'h00, 8'h4C, 8'h06, 8'h02};
      setup(16'h0200, 16'h0200);
      mem[16'h0020] = 8'hC3;
      do_reset();
      run(80, first);
      check("bcs_nt_a", dut.a, 8'hC3);
      check_loop("bcs_nt_loop", 16'h0206, 16'h0209);

      // SEC; BCS +2; LDA #11; LDX #22; JMP $0207
      prog = '{8'h38, 8'hB0, 8'h02, 8'hA9, 8'h11, 8'hA2, 8'h22, 8'h4C, 8'h07, 8'h02};
      setup(16'h0200, 16'h0200);
      do_reset();
      run(80, first);
      check("bcs_t_a", dut.a, 8'h00);
      check("bcs_t_x", dut.x, 8'h22);
      check_loop("bcs_t_loop", 16'h0207, 16'h020A);

      // $0000: BNE -16 -> $FFF2 (wraps); $FFF2: BNE FE self-loop
      prog = '{8'hD0, 8'hF0};
      setup(16'h0000, 16'h0000);
      mem[16'hFFF2] = 8'hD0;
      mem[16'hFFF3] = 8'hFE;
      do_reset();
      run(60, first);
      check("wrap_first", first, 16'h0000);
      check_loop("wrap_loop", 16'hFFF2, 16'hFFF4);

      // LDA #AA; PHA; LDA #BB; PHA; LDA #CC; PLA; PLA; JMP $020A
      prog = '{8'hA9, 8'hAA, 8'h48, 8'hA9, 8'hBB, 8'h48, 8'hA9, 8'hCC,
               8'h68, 8'h68, 8'h4C, 8'h0A, 8'h02};
      setup(16'h0200, 16'h0200);
      do_reset();
      run(120, first);
      check("push_m100", mem[16'h0100], 8'hAA);
      check("push_m101", mem[16'h0101], 8'hBB);
      check("pull_a",    dut.a, 8'hAA);
      check("pull_sp",   dut.sp, 16'h0100);
      check("pull_f",    dut.f, 8'hA4);

      // SEC; PHP; CLC; PLP; JMP $0204
      prog = '{8'h38, 8'h08, 8'h18, 8'h28, 8'h4C, 8'h04, 8'h02};
      setup(16'h0200, 16'h0200);
      do_reset();
      run(80, first);
      check("php_m100", mem[16'h0100], 8'h35);
      check("plp_f",    dut.f, 8'h35);
      check("plp_sp",   dut.sp, 16'h0100);
      check_loop("plp_loop", 16'h0204, 16'h0207);

      // Reset during the STA write cycle
      prog = '{8'hA9, 8'hC3, 8'h8D, 8'h20, 8'h00, 8'h4C, 8'h05, 8'h02};
      setup(16'h0200, 16'h0200);
      do_reset();
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = mem_wr_en;
      end
      check("abort_wr_seen", 32'(seen), 32'd1);
      rst_n = 1'b1;
      #1;
      check("abort_wr", mem_wr_en, 1'b0);
      check("abort_rd", mem_rd_en, 1'b0);
      check("abort_pc", dut.pc, 16'h0000);
      check("abort_a",  dut.a, 8'h00);
      check("abort_sp", dut.sp, 16'h0100);
      repeat (2) @(negedge clk);
      check("abort_mem", mem[16'h0020], 8'h00);
      rst_n = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = mem_rd_en && (mem_addr_out == 16'hFFFC);
      end
      check("abort_refetch", 32'(seen), 32'd1);
      run(100, first);
      check("abort_rerun_mem", mem[16'h0020], 8'hC3);

      check("rd_wr_exclusive", 32'(both_seen), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
